// File: rtl/seq_div_ctrl.sv
// seq_div_ctrl: multi-cycle unsigned restoring divider, one trial subtraction per clock
// ports: clk/rst_n (async active-low); in_valid/in_ready + dividend/divisor operand handshake;
//        out_valid/out_ready + quotient/remainder/div_by_zero result handshake
module seq_div_ctrl #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);
    localparam int CW = $clog2(N);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t        state;
    logic [N-1:0]  r, q, d;
    logic [CW-1:0] cnt;
    logic [N:0]    shifted;
    logic          borrow;
    logic [N-1:0]  r_nxt, q_nxt;
    // (N+1)-bit trial subtraction; when no borrow the true difference is below D, so N bits hold it
    assign shifted   = {r, q[N-1]};
    assign borrow    = shifted < {1'b0, d};
    assign r_nxt     = borrow ? shifted[N-1:0] : shifted[N-1:0] - d;
    assign q_nxt     = {q[N-2:0], ~borrow};
    assign in_ready  = state == IDLE;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            out_valid   <= 1'b0;
            div_by_zero <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            cnt         <= '0;
            r           <= '0;
            q           <= '0;
            d           <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    if (divisor == '0) begin
                        quotient    <= '1;
                        remainder   <= dividend;
                        div_by_zero <= 1'b1;
                        out_valid   <= 1'b1;
                        state       <= DONE;
                    end else begin
                        q           <= dividend;
                        r           <= '0;
                        d           <= divisor;
                        cnt         <= CW'(N - 1);
                        div_by_zero <= 1'b0;
                        state       <= CALC;
                    end
                end
                CALC: begin
                    r <= r_nxt;
                    q <= q_nxt;
                    if (cnt == '0) begin
                        quotient  <= q_nxt;
                        remainder <= r_nxt;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_div_ctrl.sv
// tb_seq_div_ctrl: directed table plus corner sequences on N=8, reference-model sweep on N=32
module tb_seq_div_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        iv8 = 1'b0, or8 = 1'b0, ir8, ov8, dz8;
    logic [7:0]  a8 = '0, b8 = '0, q8, r8;
    logic        iv32 = 1'b0, or32 = 1'b1, ir32, ov32, dz32;
    logic [31:0] a32 = '0, b32 = '0, q32, r32;
    int checks = 0, errors = 0;

    typedef struct {
        logic [7:0] a, b, q, r;
        logic       dbz;
        int         lat, hold;
    } vec_t;
    vec_t tbl[$];

    seq_div_ctrl #(.N(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .dividend(a8), .divisor(b8),
        .out_valid(ov8), .out_ready(or8), .quotient(q8), .remainder(r8), .div_by_zero(dz8)
    );
    seq_div_ctrl #(.N(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .dividend(a32), .divisor(b32),
        .out_valid(ov32), .out_ready(or32), .quotient(q32), .remainder(r32), .div_by_zero(dz32)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_out8(output int lat, output logic ir_bad);
        lat = 0;
        ir_bad = 1'b0;
        while (!ov8 && lat < 40) begin
            if (ir8) ir_bad = 1'b1;
            tick;
            lat++;
        end
    endtask

    task automatic run8(input vec_t v);
        int   lat;
        logic ir_bad, hold_bad;
        chk("in_ready_idle", ir8, 1'b1);
        iv8 = 1'b1; a8 = v.a; b8 = v.b; or8 = 1'b0;
        tick;
        iv8 = 1'b0; a8 = '0; b8 = '0;
        chk("in_ready_busy", ir8, 1'b0);
        wait_out8(lat, ir_bad);
        chk("latency", lat, v.lat);
        chk("in_ready_low_calc", ir_bad, 1'b0);
        chk("quotient", q8, v.q);
        chk("remainder", r8, v.r);
        chk("div_by_zero", dz8, v.dbz);
        hold_bad = 1'b0;
        for (int h = 0; h < v.hold; h++) begin
            tick;
            if (ov8 !== 1'b1 || q8 !== v.q || r8 !== v.r || dz8 !== v.dbz || ir8 !== 1'b0) hold_bad = 1'b1;
        end
        chk("hold_stable", hold_bad, 1'b0);
        or8 = 1'b1;
        tick;
        or8 = 1'b0;
        chk("out_valid_drop", ov8, 1'b0);
        chk("in_ready_back", ir8, 1'b1);
        chk("quotient_retained", q8, v.q);
    endtask

    initial begin
        int          lat;
        logic        ir_bad;
        logic [31:0] ea, eb, eq, er;
        int          elat;
        tbl.push_back('{a: 8'd200, b: 8'd7,   q: 8'd28,  r: 8'd4,   dbz: 1'b0, lat: 8, hold: 5});
        tbl.push_back('{a: 8'd77,  b: 8'd0,   q: 8'hFF,  r: 8'd77,  dbz: 1'b1, lat: 0, hold: 2});
        tbl.push_back('{a: 8'd100, b: 8'd10,  q: 8'd10,  r: 8'd0,   dbz: 1'b0, lat: 8, hold: 0});
        tbl.push_back('{a: 8'd0,   b: 8'd5,   q: 8'd0,   r: 8'd0,   dbz: 1'b0, lat: 8, hold: 0});
        tbl.push_back('{a: 8'd255, b: 8'd255, q: 8'd1,   r: 8'd0,   dbz: 1'b0, lat: 8, hold: 1});
        tbl.push_back('{a: 8'd254, b: 8'd255, q: 8'd0,   r: 8'd254, dbz: 1'b0, lat: 8, hold: 0});
        tbl.push_back('{a: 8'd255, b: 8'd16,  q: 8'd15,  r: 8'd15,  dbz: 1'b0, lat: 8, hold: 0});
        tbl.push_back('{a: 8'd128, b: 8'd2,   q: 8'd64,  r: 8'd0,   dbz: 1'b0, lat: 8, hold: 0});

        tick;
        tick;
        chk("rst_out_valid", ov8, 1'b0);
        chk("rst_in_ready", ir8, 1'b1);
        chk("rst_quotient", q8, 8'd0);
        chk("rst_remainder", r8, 8'd0);
        chk("rst_div_by_zero", dz8, 1'b0);
        rst_n = 1'b1;
        tick;

        foreach (tbl[i]) run8(tbl[i]);

        // back-to-back with in_valid held; operands changed during CALC must be ignored
        iv8 = 1'b1; a8 = 8'd5; b8 = 8'd9; or8 = 1'b0;
        tick;
        a8 = 8'd255; b8 = 8'd1;
        wait_out8(lat, ir_bad);
        chk("b2b_lat1", lat, 8);
        chk("b2b_q1", q8, 8'd0);
        chk("b2b_r1", r8, 8'd5);
        or8 = 1'b1;
        tick;
        or8 = 1'b0;
        chk("b2b_ready_after_hs", ir8, 1'b1);
        tick;
        iv8 = 1'b0;
        chk("b2b_second_accept", ir8, 1'b0);
        wait_out8(lat, ir_bad);
        chk("b2b_lat2", lat, 8);
        chk("b2b_q2", q8, 8'd255);
        chk("b2b_r2", r8, 8'd0);
        or8 = 1'b1;
        tick;
        or8 = 1'b0;

        // reset pulse in the middle of a divide
        iv8 = 1'b1; a8 = 8'd200; b8 = 8'd7;
        tick;
        iv8 = 1'b0;
        repeat (4) tick;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid_async", ov8, 1'b0);
        chk("abort_quotient_async", q8, 8'd0);
        tick;
        rst_n = 1'b1;
        tick;
        chk("abort_in_ready", ir8, 1'b1);
        chk("abort_out_valid", ov8, 1'b0);
        chk("abort_remainder", r8, 8'd0);
        repeat (10) tick;
        chk("abort_no_result", ov8, 1'b0);
        run8('{a: 8'd50, b: 8'd3, q: 8'd16, r: 8'd2, dbz: 1'b0, lat: 8, hold: 0});

        // N=32 sweep against a reference model
        for (int i = 0; i < 1000; i++) begin
            ea = $urandom;
            eb = $urandom;
            case (i % 5)
                0: eb = 32'd1;
                1: begin ea = ea >> (i % 31 + 1); eb = ea + 32'd1 + (eb >> 2); if (eb <= ea) eb = 32'hFFFFFFFF; end
                2: ea = 32'hFFFFFFFF;
                3: eb = eb >> (i % 32);
                default: ;
            endcase
            if (i == 7) eb = 32'd0;
            eq = (eb == 0) ? 32'hFFFFFFFF : ea / eb;
            er = (eb == 0) ? ea : ea % eb;
            elat = (eb == 0) ? 0 : 32;
            iv32 = 1'b1; a32 = ea; b32 = eb;
            tick;
            iv32 = 1'b0;
            lat = 0;
            while (!ov32 && lat < 80) begin
                tick;
                lat++;
            end
            chk("n32_latency", lat, elat);
            chk("n32_quotient", q32, eq);
            chk("n32_remainder", r32, er);
            chk("n32_dbz", dz32, eb == 0);
            tick;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
